// File: rtl/alu_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer_if
//   Bundles the three buses around the accumulator-ALU command issuer:
//     cmd_*  : command channel, valid/ready (initiator -> issuer)
//     alu_*  : ALU selector/operand outputs and result/overflow inputs
//     rsp_*  : response channel, valid/ready (issuer -> consumer)
//   master : environment side (drives commands, ALU result, rsp_ready)
//   slave  : issuer side
// ---------------------------------------------------------------------------
interface alu_cmd_issuer_if #(
    parameter int unsigned WIDTH = 8
);
    // command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [1:0]       cmd_mode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    // ALU side
    logic [2:0]       alu_in_sel;
    logic [6:0]       alu_out_sel;
    logic [WIDTH-1:0] alu_num1;
    logic [WIDTH-1:0] alu_num2;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;

    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_mode, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_in_sel, alu_out_sel, alu_num1, alu_num2,
        output alu_result, alu_overflow,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mode, cmd_a, cmd_b,
        output cmd_ready,
        output alu_in_sel, alu_out_sel, alu_num1, alu_num2,
        input  alu_result, alu_overflow,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//   Initiator-side driver for the accumulator ALU. Accepts an encoded command,
//   drives one-hot mode/op selectors and operands for ALU_LAT cycles, samples
//   result and overflow, and returns them on a response channel. Tracks a
//   sticky overflow flag that blocks persist-mode reuse of a faulted
//   accumulator until a load- or reset-mode command is accepted.
//
//   Ports:
//     clk      : rising-edge clock
//     rst      : asynchronous active-low reset
//     bus      : alu_cmd_issuer_if.slave (cmd_*, alu_*, rsp_*)
//     err_flag : sticky ALU overflow flag
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_issuer_if.slave   bus,
    output logic              err_flag
);

    localparam int unsigned    CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(ALU_LAT - 1);

    localparam logic [1:0] MODE_PERSIST = 2'd0;
    localparam logic [1:0] MODE_RESET   = 2'd2;
    localparam logic [1:0] MODE_BAD     = 2'd3;
    localparam logic [2:0] OP_BAD       = 3'd7;

    localparam logic [2:0] IN_SEL_IDLE  = 3'b100;
    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_OVF       = 2'b01;
    localparam logic [1:0] ST_ILLEGAL   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       in_sel, in_sel_n;
    logic [6:0]       out_sel, out_sel_n;
    logic [WIDTH-1:0] num1, num1_n;
    logic [WIDTH-1:0] num2, num2_n;
    logic [WIDTH-1:0] rdata, rdata_n;
    logic [1:0]       rstat, rstat_n;
    logic             err, err_n;

    logic             accept;
    logic             illegal;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            in_sel  <= IN_SEL_IDLE;
            out_sel <= '0;
            num1    <= '0;
            num2    <= '0;
            rdata   <= '0;
            rstat   <= ST_OK;
            err     <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            in_sel  <= in_sel_n;
            out_sel <= out_sel_n;
            num1    <= num1_n;
            num2    <= num2_n;
            rdata   <= rdata_n;
            rstat   <= rstat_n;
            err     <= err_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        in_sel_n  = in_sel;
        out_sel_n = out_sel;
        num1_n    = num1;
        num2_n    = num2;
        rdata_n   = rdata;
        rstat_n   = rstat;
        err_n     = err;

        accept  = (state == S_IDLE) && bus.cmd_valid;
        // Persist while faulted would silently reuse a corrupted accumulator.
        illegal = (bus.cmd_op == OP_BAD) || (bus.cmd_mode == MODE_BAD) ||
                  ((bus.cmd_mode == MODE_PERSIST) && err);

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_n = S_RESP;
                        rdata_n = '0;
                        rstat_n = ST_ILLEGAL;
                    end else begin
                        state_n   = S_ISSUE;
                        cnt_n     = CNT_LOAD;
                        // Encodings are ordered MSB-first in the one-hot vectors.
                        in_sel_n  = 3'b100 >> bus.cmd_mode;
                        out_sel_n = 7'b1000000 >> bus.cmd_op;
                        num1_n    = (bus.cmd_mode == MODE_RESET) ? '0 : bus.cmd_a;
                        num2_n    = bus.cmd_b;
                        if (bus.cmd_mode != MODE_PERSIST) begin
                            err_n = 1'b0;
                        end
                    end
                end
            end

            S_ISSUE: begin
                if (cnt == '0) begin
                    state_n   = S_RESP;
                    rdata_n   = bus.alu_result;
                    rstat_n   = bus.alu_overflow ? ST_OVF : ST_OK;
                    if (bus.alu_overflow) begin
                        err_n = 1'b1;
                    end
                    in_sel_n  = IN_SEL_IDLE;
                    out_sel_n = '0;
                    num1_n    = '0;
                    num2_n    = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_data    = rdata;
    assign bus.rsp_status  = rstat;
    assign bus.alu_in_sel  = in_sel;
    assign bus.alu_out_sel = out_sel;
    assign bus.alu_num1    = num1;
    assign bus.alu_num2    = num2;
    assign err_flag        = err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
//   Directed bench for alu_cmd_issuer (WIDTH=8, ALU_LAT=2). Inputs change and
//   outputs are sampled on the falling edge; the ALU result is driven by the
//   bench only around the expected capture edge.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_flag;

    int vectors    = 0;
    int miscompares = 0;

    alu_cmd_issuer_if #(.WIDTH(8)) bus ();

    alu_cmd_issuer #(
        .WIDTH   (8),
        .ALU_LAT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Drive a command at a falling edge; returns at the falling edge of cycle 1.
    task automatic send_cmd(input logic [1:0] mode, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Complete the response handshake; returns at the next falling edge.
    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_flag); end
        vectors++; if (bus.alu_in_sel !== 3'b100) begin miscompares++; $display("FAIL reset_in_sel got %b want 100", bus.alu_in_sel); end
        vectors++; if (bus.alu_out_sel !== 7'b0) begin miscompares++; $display("FAIL reset_out_sel got %b want 0000000", bus.alu_out_sel); end
        vectors++; if (bus.rsp_data !== 8'h00 || bus.rsp_status !== 2'b00) begin miscompares++; $display("FAIL reset_rsp got %h/%b want 00/00", bus.rsp_data, bus.rsp_status); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_hs got rdy=%b vld=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        vectors++; if (bus.alu_in_sel !== 3'b100 || bus.alu_num1 !== 8'h00 || bus.alu_num2 !== 8'h00) begin miscompares++; $display("FAIL post_reset_alu got sel=%b n1=%h n2=%h want 100/00/00", bus.alu_in_sel, bus.alu_num1, bus.alu_num2); end
    endtask

    task automatic test_legal_add();
        bus.alu_result = 8'hAA; bus.alu_overflow = 1'b1;
        send_cmd(2'd1, 3'd4, 8'd3, 8'd5);
        // cycle 1
        vectors++; if (bus.alu_in_sel !== 3'b010) begin miscompares++; $display("FAIL add_c1_in_sel got %b want 010", bus.alu_in_sel); end
        vectors++; if (bus.alu_out_sel !== 7'b0000100) begin miscompares++; $display("FAIL add_c1_out_sel got %b want 0000100", bus.alu_out_sel); end
        vectors++; if (bus.alu_num1 !== 8'd3 || bus.alu_num2 !== 8'd5) begin miscompares++; $display("FAIL add_c1_nums got %0d/%0d want 3/5", bus.alu_num1, bus.alu_num2); end
        vectors++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_c1_hs got rdy=%b vld=%b want 0/0", bus.cmd_ready, bus.rsp_valid); end
        bus.alu_result = 8'd8; bus.alu_overflow = 1'b0;
        @(negedge clk);
        // cycle 2
        vectors++; if (bus.alu_in_sel !== 3'b010 || bus.alu_out_sel !== 7'b0000100) begin miscompares++; $display("FAIL add_c2_sel got %b/%b want 010/0000100", bus.alu_in_sel, bus.alu_out_sel); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_c2_rsp_valid got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        bus.alu_result = 8'h55; bus.alu_overflow = 1'b1;
        // cycle 3
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_c3_rsp_valid got %b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_data !== 8'd8 || bus.rsp_status !== 2'b00) begin miscompares++; $display("FAIL add_rsp got %0d/%b want 8/00", bus.rsp_data, bus.rsp_status); end
        vectors++; if (bus.alu_in_sel !== 3'b100 || bus.alu_out_sel !== 7'b0) begin miscompares++; $display("FAIL add_c3_idle got %b/%b want 100/0000000", bus.alu_in_sel, bus.alu_out_sel); end
        vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL add_err got %b want 0", err_flag); end
        finish_rsp();
        bus.alu_overflow = 1'b0;
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL add_done got vld=%b rdy=%b want 0/1", bus.rsp_valid, bus.cmd_ready); end
    endtask

    task automatic test_overflow();
        send_cmd(2'd1, 3'd6, 8'd20, 8'd20);
        vectors++; if (bus.alu_out_sel !== 7'b0000001 || bus.alu_in_sel !== 3'b010) begin miscompares++; $display("FAIL mult_sel got %b/%b want 0000001/010", bus.alu_out_sel, bus.alu_in_sel); end
        @(negedge clk);
        bus.alu_result = 8'd144; bus.alu_overflow = 1'b1;
        @(negedge clk);
        bus.alu_overflow = 1'b0;
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b01 || bus.rsp_data !== 8'd144) begin miscompares++; $display("FAIL mult_rsp got vld=%b st=%b d=%0d want 1/01/144", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
        vectors++; if (err_flag !== 1'b1) begin miscompares++; $display("FAIL mult_err got %b want 1", err_flag); end
        finish_rsp();
        // persist while faulted is refused
        send_cmd(2'd0, 3'd4, 8'd1, 8'd1);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b10 || bus.rsp_data !== 8'd0) begin miscompares++; $display("FAIL persist_blocked got vld=%b st=%b d=%0d want 1/10/0", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
        vectors++; if (bus.alu_in_sel !== 3'b100 || bus.alu_out_sel !== 7'b0) begin miscompares++; $display("FAIL persist_blocked_alu got %b/%b want 100/0000000", bus.alu_in_sel, bus.alu_out_sel); end
        vectors++; if (err_flag !== 1'b1) begin miscompares++; $display("FAIL persist_blocked_err got %b want 1", err_flag); end
        finish_rsp();
        // reset-mode command clears the fault and zeroes num1
        send_cmd(2'd2, 3'd0, 8'd77, 8'd9);
        vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL reset_mode_err got %b want 0", err_flag); end
        vectors++; if (bus.alu_in_sel !== 3'b001 || bus.alu_out_sel !== 7'b1000000) begin miscompares++; $display("FAIL reset_mode_sel got %b/%b want 001/1000000", bus.alu_in_sel, bus.alu_out_sel); end
        vectors++; if (bus.alu_num1 !== 8'd0 || bus.alu_num2 !== 8'd9) begin miscompares++; $display("FAIL reset_mode_nums got %0d/%0d want 0/9", bus.alu_num1, bus.alu_num2); end
        @(negedge clk);
        bus.alu_result = 8'd0;
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00 || bus.rsp_data !== 8'd0) begin miscompares++; $display("FAIL reset_mode_rsp got vld=%b st=%b d=%0d want 1/00/0", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        // leave a nonzero rsp_data so the zeroing is observable
        send_cmd(2'd1, 3'd1, 8'h0F, 8'h30);
        @(negedge clk);
        bus.alu_result = 8'h3F;
        @(negedge clk);
        finish_rsp();
        send_cmd(2'd1, 3'd7, 8'd4, 8'd4);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b10 || bus.rsp_data !== 8'd0) begin miscompares++; $display("FAIL op7 got vld=%b st=%b d=%0d want 1/10/0", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
        vectors++; if (bus.alu_out_sel !== 7'b0) begin miscompares++; $display("FAIL op7_out_sel got %b want 0000000", bus.alu_out_sel); end
        finish_rsp();
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL op7_ready got %b want 1", bus.cmd_ready); end
        send_cmd(2'd3, 3'd0, 8'd4, 8'd4);
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b10 || bus.rsp_data !== 8'd0) begin miscompares++; $display("FAIL mode3 got vld=%b st=%b d=%0d want 1/10/0", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
        vectors++; if (bus.alu_out_sel !== 7'b0 || bus.alu_in_sel !== 3'b100) begin miscompares++; $display("FAIL mode3_alu got %b/%b want 0000000/100", bus.alu_out_sel, bus.alu_in_sel); end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        send_cmd(2'd1, 3'd3, 8'h0F, 8'hF0);
        @(negedge clk);
        bus.alu_result = 8'hFF; bus.alu_overflow = 1'b0;
        @(negedge clk);
        bus.alu_result = 8'h12;
        // a second command is offered but must be ignored while busy
        bus.cmd_valid = 1'b1; bus.cmd_mode = 2'd1; bus.cmd_op = 3'd7;
        for (int unsigned i = 0; i < 5; i++) begin
            vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hFF || bus.rsp_status !== 2'b00) begin miscompares++; $display("FAIL bp_hold[%0d] got vld=%b d=%h st=%b want 1/ff/00", i, bus.rsp_valid, bus.rsp_data, bus.rsp_status); end
            vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %b want 0", i, bus.cmd_ready); end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        finish_rsp();
        vectors++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_extra got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid_issue();
        send_cmd(2'd1, 3'd4, 8'd10, 8'd20);
        @(negedge clk);
        bus.alu_result = 8'd30; bus.alu_overflow = 1'b1;
        rst = 1'b0;
        #1;
        vectors++; if (bus.alu_in_sel !== 3'b100 || bus.alu_out_sel !== 7'b0 || bus.alu_num1 !== 8'd0) begin miscompares++; $display("FAIL mid_rst_alu got %b/%b/%0d want 100/0000000/0", bus.alu_in_sel, bus.alu_out_sel, bus.alu_num1); end
        vectors++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_hs got rdy=%b vld=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (bus.rsp_valid !== 1'b0 || err_flag !== 1'b0) begin miscompares++; $display("FAIL mid_rst_quiet[%0d] got vld=%b err=%b want 0/0", i, bus.rsp_valid, err_flag); end
        end
        vectors++; if (bus.rsp_data !== 8'd0 || bus.rsp_status !== 2'b00) begin miscompares++; $display("FAIL mid_rst_rsp got %0d/%b want 0/00", bus.rsp_data, bus.rsp_status); end
        bus.alu_overflow = 1'b0;
    endtask

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 3'd0;
        bus.cmd_mode     = 2'd0;
        bus.cmd_a        = 8'd0;
        bus.cmd_b        = 8'd0;
        bus.alu_result   = 8'd0;
        bus.alu_overflow = 1'b0;
        bus.rsp_ready    = 1'b0;
        @(negedge clk);
        test_reset();
        test_legal_add();
        test_overflow();
        test_illegal();
        test_backpressure();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Initiator-side driver for the 8-bit accumulator ALU. It accepts encoded operation commands over a valid/ready interface and drives the ALU's one-hot input-mode and operation selectors and its operands. It holds those inputs for the ALU's fixed latency, then captures the result and overflow flag and returns them as a response over a second valid/ready interface. It also tracks the ALU's overflow error condition so that a faulted accumulator is never silently reused.

## Interface

Parameters:
- WIDTH, 8, operand/result width
- ALU_LAT, 2, cycles ALU inputs are held before result is sampled (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  issuer can accept a command
- cmd_op  in  3  0=and 1=or 2=not 3=xor 4=add 5=sub 6=mult, 7=illegal
- cmd_mode  in  2  0=persist 1=load 2=reset, 3=illegal
- cmd_a  in  WIDTH  accumulator-side operand
- cmd_b  in  WIDTH  second operand
- alu_in_sel  out  3  one-hot mode: [2]=persist [1]=load [0]=reset
- alu_out_sel  out  7  one-hot op: [6]=and [5]=or [4]=not [3]=xor [2]=add [1]=sub [0]=mult
- alu_num1  out  WIDTH  operand to ALU first input
- alu_num2  out  WIDTH  operand to ALU second input
- alu_result  in  WIDTH  ALU output value
- alu_overflow  in  1  ALU overflow flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  captured result
- rsp_status  out  2  00=ok 01=overflow 10=illegal
- err_flag  out  1  sticky ALU overflow flag

## Operation

- FSM states: S_IDLE, S_ISSUE, S_RESP.
- S_IDLE:
  - cmd_ready=1.
  - ALU outputs at idle values: alu_in_sel=3'b100 (persist), alu_out_sel=0, alu_num1=0, alu_num2=0.
- Accept on cmd_valid & cmd_ready at a rising edge. The command is illegal if any of these holds:
  - cmd_op=7
  - cmd_mode=3
  - cmd_mode=persist while err_flag=1
- Legal command → S_ISSUE. Drive:
  - alu_in_sel: one-hot of cmd_mode.
  - alu_out_sel: one-hot of cmd_op.
  - alu_num1=cmd_a (0 when mode=reset).
  - alu_num2=cmd_b.
  - All values are registered at accept and held constant for ALU_LAT cycles.
  - A cycle counter loads ALU_LAT-1 at accept and decrements each cycle.
- At the edge ending the last S_ISSUE cycle (counter=0):
  - Capture rsp_data=alu_result.
  - rsp_status = alu_overflow ? 01 : 00.
  - Go to S_RESP; ALU outputs return to idle values.
- Illegal command → straight to S_RESP with rsp_data=0 and rsp_status=10. ALU outputs stay at idle values.
- S_RESP:
  - rsp_valid=1; rsp_data and rsp_status held stable.
  - On rsp_valid & rsp_ready → S_IDLE.
- err_flag:
  - Set at capture when alu_overflow=1.
  - Cleared when a legal load- or reset-mode command is accepted.
  - A not-op still reads the accumulator; persist is blocked while the flag is set.
- cmd_* inputs are ignored outside S_IDLE. cmd_ready=0 in S_ISSUE and S_RESP.

## Timing

- Reset (rst=0, asynchronous), all outputs immediately:
  - S_IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_status=00, err_flag=0.
  - ALU outputs at idle values; counter=0.
- Reset mid-S_ISSUE or mid-S_RESP: the command and pending response are discarded, and no response is produced after reset release.
- Accept at edge t0:
  - ALU inputs are valid in cycles 1..ALU_LAT after t0.
  - Result is sampled at edge t0+ALU_LAT.
  - rsp_valid goes high in the cycle after that edge: cycle ALU_LAT+1 after t0.
- Illegal command: rsp_valid is high in cycle 1 after accept.
- rsp_ready may be high before rsp_valid. The handshake completes in the first cycle where both are high.
- cmd_ready rises in the cycle after the response handshake edge. Minimum command spacing is ALU_LAT+2 cycles (legal), 2 cycles (illegal).
- cmd_valid may stay asserted continuously; each accept consumes exactly one command.
- alu_overflow and alu_result are sampled only at the capture edge; values in other cycles are ignored.

## Test plan

All tests use WIDTH=8, ALU_LAT=2.

- **Reset values.** Hold rst=0, then release → cmd_ready=1, rsp_valid=0, err_flag=0, alu_in_sel=100, alu_out_sel=0. All stable with no stimulus.
- **Legal add.** Load-mode add (mode=1, op=4, a=3, b=5), model ALU returns 8 at the sample edge → alu_in_sel=010 and alu_out_sel=0000100 for exactly 2 cycles. Then rsp_valid in cycle 3 after accept, rsp_data=8, rsp_status=00.
- **Overflow and sticky error.** Load-mode mult 20×20, model returns 144 with overflow=1 → rsp_status=01, rsp_data=144, err_flag=1. Next persist-mode add → rsp_status=10 in cycle 1, ALU outputs untouched. Then a reset-mode command → err_flag=0 after accept.
- **Illegal encodings.** op=7, then mode=3 → each gives rsp_status=10, rsp_data=0 one cycle after accept; alu_out_sel stays 0 throughout.
- **Response backpressure.** Hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_data/rsp_status stable and cmd_ready=0. Raise rsp_ready → cmd_ready=1 one cycle after the handshake.
- **Reset mid-issue.** Assert rst in the 2nd S_ISSUE cycle → outputs go to reset values immediately; no rsp_valid pulse after release.
